// File: rtl/multi_divider.sv
// Bank of NCH independent programmable clock dividers. Each channel runs a
// period of P+1 cycles with H high cycles; new configs are double-buffered.

module multi_divider_ch #(
    parameter int WIDTH = 24
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             load_stb,
    input  logic             sync,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] high,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] h;
    } cfg_t;

    cfg_t             act;
    cfg_t             shd;
    cfg_t             cfg_in;
    cfg_t             cfg_new;
    logic [WIDTH-1:0] pos;
    logic [WIDTH-1:0] pos_inc;
    logic             run;
    logic             wrap;

    assign cfg_in  = '{p: period, h: high};
    assign wrap    = en & (~run | sync | (pos == act.p));
    // A strobe landing on the wrap edge bypasses the shadow entirely.
    assign cfg_new = load_stb ? cfg_in : (pending ? shd : act);
    // pos < act.p whenever this is used, so it cannot overflow.
    assign pos_inc = pos + 1'b1;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            act     <= '0;
            shd     <= '0;
            pos     <= '0;
            run     <= 1'b0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
            pending <= 1'b0;
        end else if (en) begin
            if (load_stb)
                shd <= cfg_in;
            if (wrap) begin
                pos     <= '0;
                run     <= 1'b1;
                tick    <= 1'b1;
                clk_out <= (cfg_new.h != '0);
                act     <= cfg_new;
                pending <= 1'b0;
            end else begin
                pos     <= pos_inc;
                tick    <= 1'b0;
                clk_out <= (pos_inc < act.h);
                if (load_stb)
                    pending <= 1'b1;
            end
        end else begin
            pos     <= '0;
            run     <= 1'b0;
            tick    <= 1'b0;
            clk_out <= 1'b0;
            if (load_stb) begin
                shd     <= cfg_in;
                pending <= 1'b1;
            end else if (pending && !run) begin
                // Idle channel: nothing to phase-align against, apply now.
                act     <= shd;
                pending <= 1'b0;
            end
        end
    end

endmodule

module multi_divider #(
    parameter int WIDTH = 24,
    parameter int NCH   = 4
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic [NCH-1:0]       en,
    input  logic [NCH*WIDTH-1:0] period,
    input  logic [NCH*WIDTH-1:0] high,
    input  logic                 load_stb,
    input  logic                 sync,
    output logic [NCH-1:0]       clk_out,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       pending
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic ch_clk;
        logic ch_tick;
        logic ch_pend;

        multi_divider_ch #(.WIDTH(WIDTH)) u_ch (
            .clk_in   (clk_in),
            .rst      (rst),
            .en       (en[i]),
            .load_stb (load_stb),
            .sync     (sync),
            .period   (period[i*WIDTH +: WIDTH]),
            .high     (high[i*WIDTH +: WIDTH]),
            .clk_out  (ch_clk),
            .tick     (ch_tick),
            .pending  (ch_pend)
        );

        assign clk_out[i] = ch_clk;
        assign tick[i]    = ch_tick;
        assign pending[i] = ch_pend;
    end

endmodule

// File: tb/tb_multi_divider.sv
// Directed bench for multi_divider (WIDTH=8, NCH=2); outputs sampled on falling edge.

module tb_multi_divider;

    localparam int WIDTH = 8;
    localparam int NCH   = 2;

    logic                 clk_in = 1'b0;
    logic                 rst;
    logic [NCH-1:0]       en;
    logic [NCH*WIDTH-1:0] period;
    logic [NCH*WIDTH-1:0] high;
    logic                 load_stb;
    logic                 sync;
    logic [NCH-1:0]       clk_out;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       pending;

    int n_chk  = 0;
    int n_fail = 0;

    // Expected waveform per channel: P, H, cycle index of the next edge, enabled.
    int ep[NCH];
    int eh[NCH];
    int ek[NCH];
    bit eon[NCH];

    always #5 clk_in = ~clk_in;

    multi_divider #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
        .period   (period),
        .high     (high),
        .load_stb (load_stb),
        .sync     (sync),
        .clk_out  (clk_out),
        .tick     (tick),
        .pending  (pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic load(input logic [7:0] p0, input logic [7:0] h0,
                        input logic [7:0] p1, input logic [7:0] h1);
        period   = {p1, p0};
        high     = {h1, h0};
        load_stb = 1'b1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            for (int ch = 0; ch < NCH; ch++) begin
                chk($sformatf("ch%0d_clk", ch), 32'(clk_out[ch]),
                    eon[ch] ? 32'(ek[ch] < eh[ch]) : 32'd0);
                chk($sformatf("ch%0d_tick", ch), 32'(tick[ch]),
                    eon[ch] ? 32'(ek[ch] == 0) : 32'd0);
                if (eon[ch])
                    ek[ch] = (ek[ch] == ep[ch]) ? 0 : ek[ch] + 1;
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = '0; period = '0; high = '0; load_stb = 1'b0; sync = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            ep[ch] = 0; eh[ch] = 0; ek[ch] = 0; eon[ch] = 1'b0;
        end

        // Reset state
        repeat (2) @(negedge clk_in);
        chk("rst_clk", 32'(clk_out), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);
        rst = 1'b0;

        // Load while idle, then enable: P=5 H=3 -> 1,1,1,0,0,0
        load(5, 3, 5, 2);
        @(negedge clk_in);
        load_stb = 1'b0;
        chk("idle_pend_set", 32'(pending), 32'd3);
        @(negedge clk_in);
        chk("idle_pend_apply", 32'(pending), 32'd0);
        en = 2'b01;
        ep[0] = 5; eh[0] = 3; ek[0] = 0; eon[0] = 1'b1;
        run(15);

        // Mid-period load at pos=2, overwritten once while pending; last wins (P=3 H=1)
        load(2, 2, 5, 2);
        run(1);
        chk("mid_pend0", 32'(pending[0]), 32'd1);
        load(3, 1, 5, 2);
        run(1);
        load_stb = 1'b0;
        chk("mid_pend1", 32'(pending[0]), 32'd1);
        run(1);
        chk("mid_pend2", 32'(pending[0]), 32'd1);
        ep[0] = 3; eh[0] = 1;
        run(1);
        chk("mid_applied", 32'(pending[0]), 32'd0);
        run(7);

        // Disable, reload P=7 H=4, re-enable: 4 high / 4 low
        en = 2'b00; eon[0] = 1'b0;
        load(7, 4, 5, 2);
        run(1);
        load_stb = 1'b0;
        chk("dis_pend", 32'(pending[0]), 32'd1);
        run(1);
        chk("dis_apply", 32'(pending[0]), 32'd0);
        en = 2'b01;
        ep[0] = 7; eh[0] = 4; ek[0] = 0; eon[0] = 1'b1;
        run(16);
        chk("p7_pend", 32'(pending[0]), 32'd0);

        // Loads coinciding with wrap: H=0, then H>P, then P=0
        load(3, 0, 5, 2);
        ep[0] = 3; eh[0] = 0;
        run(1);
        load_stb = 1'b0;
        chk("wrap_load_pend", 32'(pending[0]), 32'd0);
        run(7);
        load(5, 9, 5, 2);
        ep[0] = 5; eh[0] = 9;
        run(1);
        load_stb = 1'b0;
        run(11);
        load(0, 1, 5, 2);
        ep[0] = 0; eh[0] = 1;
        run(1);
        load_stb = 1'b0;
        run(4);

        // Two channels out of phase, then sync aligns them
        en = 2'b00; eon[0] = 1'b0;
        load(3, 2, 5, 3);
        run(1);
        load_stb = 1'b0;
        run(1);
        en = 2'b01;
        ep[0] = 3; eh[0] = 2; ek[0] = 0; eon[0] = 1'b1;
        run(2);
        en = 2'b11;
        ep[1] = 5; eh[1] = 3; ek[1] = 0; eon[1] = 1'b1;
        run(3);
        sync = 1'b1; ek[0] = 0; ek[1] = 0;
        run(1);
        sync = 1'b0;
        run(6);
        en = 2'b01; eon[1] = 1'b0;
        run(2);
        sync = 1'b1; ek[0] = 0;
        run(1);
        sync = 1'b0;
        run(4);

        // Async reset between edges discards pending config
        load(3, 2, 5, 3);
        run(1);
        load_stb = 1'b0;
        chk("pre_rst_pend", 32'(pending[1]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_clk", 32'(clk_out), 32'd0);
        chk("async_tick", 32'(tick), 32'd0);
        chk("async_pend", 32'(pending), 32'd0);
        @(negedge clk_in);
        chk("held_clk", 32'(clk_out), 32'd0);
        chk("held_tick", 32'(tick), 32'd0);
        rst = 1'b0;
        en  = 2'b11;
        for (int ch = 0; ch < NCH; ch++) begin
            ep[ch] = 0; eh[ch] = 0; ek[ch] = 0; eon[ch] = 1'b1;
        end
        run(4);
        chk("post_rst_pend", 32'(pending), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_divider.md
MULTI_DIVIDER -- requirements
Module: multi_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 24, counter/config width per channel.
REQ-002 SHALL have parameter NCH, default 4, number of independent divider channels (1..16).
REQ-003 clk_in  input  1  sole clock; all state changes on its rising edge except reset.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  NCH  per-channel run enable; bit i controls channel i.
REQ-006 period  input  NCH*WIDTH  P for channel i at [i*WIDTH +: WIDTH]; output period = P+1 clk_in cycles.
REQ-007 high  input  NCH*WIDTH  H for channel i, same packing; number of high cycles per period.
REQ-008 load_stb  input  1  one-cycle strobe; captures all period/high fields into shadow registers.
REQ-009 sync  input  1  one-cycle strobe; restarts all enabled channels at period start.
REQ-010 clk_out  output  NCH  registered divided clock per channel.
REQ-011 tick  output  NCH  registered one-cycle pulse in the first cycle of each period.
REQ-012 pending  output  NCH  shadow config captured and not yet applied.

Function
REQ-013 Each channel SHALL hold active regs P_a/H_a, shadow regs P_s/H_s, position counter pos, run flag, pending flag.
REQ-014 wrap(i) SHALL be (en[i] & (!run | sync | pos==P_a)); evaluated per edge.
REQ-015 en[i]=1, wrap: pos<=0, run<=1, tick<=1, clk_out<=(0 < H of new period).
REQ-016 en[i]=1, no wrap: pos<=pos+1, tick<=0, clk_out<=(pos+1 < H_a).
REQ-017 Cycle k (0..P) of a period SHALL show clk_out=1 iff k<H; H=0 gives constant low, H>P constant high.
REQ-018 en[i]=0: next edge pos<=0, run<=0, clk_out<=0, tick<=0; sync ignored.
REQ-019 load_stb SHALL write P_s/H_s for all channels and set pending=1 for each.
REQ-020 Pending config SHALL transfer to P_a/H_a at the next wrap and clear pending; the new period uses the new values from cycle 0.
REQ-021 Channel not running (run=0, en=0): pending config SHALL transfer on the next edge.
REQ-022 load_stb coinciding with wrap: new input values SHALL apply directly to that wrap, pending stays 0.
REQ-023 load_stb while pending=1: shadow overwritten, pending stays 1; only the latest values apply.
REQ-024 sync with en=1 SHALL force wrap in every enabled channel on the same edge, phase-aligning them; pending config applies.
REQ-025 First enabled edge after en rises SHALL be a wrap (tick=1), giving a full first period.
REQ-026 P=0: tick every cycle; clk_out=1 constantly if H>=1, else 0.
REQ-027 Arithmetic: pos, comparisons unsigned WIDTH bits; pos never exceeds P_a, no wrap-around past 2^WIDTH-1.
REQ-028 P=2N+1, H=N+1 SHALL give 50% duty f_out=f_in/(2(N+1)), the established divider ratio.
REQ-029 No combinational path from any input to any output.

Reset
REQ-030 rst=1 SHALL immediately clear clk_out, tick, pending, pos, run, P_a, H_a, P_s, H_s to 0, regardless of clock.
REQ-031 Reset mid-period SHALL discard the period and pending config; after release channels restart per REQ-025 with P=0/H=0 until loaded.

Verification (WIDTH=8, NCH=2)
REQ-032 en=0, load_stb with P0=5,H0=3, then en[0]=1 -> clk_out[0] 1,1,1,0,0,0 repeating, tick[0] every 6 cycles from first enabled edge.
REQ-033 P0=7,H0=4 -> 4 high, 4 low, f_in/8; pending[0] low throughout after apply.
REQ-034 Running P0=5,H0=3, load_stb P0=3,H0=1 at pos=2 -> pending[0]=1 until wrap, current period finishes 1,1,1,0,0,0, then 1,0,0,0 repeating.
REQ-035 H0=0 -> clk_out[0] constant 0 with ticks; H0=9,P0=5 -> constant 1; P0=0,H0=1 -> tick and clk_out constant 1.
REQ-036 ch0 P=3, ch1 P=5 out of phase; pulse sync -> both tick next edge, aligned; repeat with en[1]=0 -> ch1 stays 0.
REQ-037 Assert rst between edges mid-period -> all outputs 0 within the same cycle; release -> pending=0, outputs follow P=0/H=0.
